gate_sweep_ctrl: RTL and testbench
==================================

// Module: gate_sweep_ctrl
// PURPOSE
//   Sequencer that exercises an external 2-input gate (NAND by default) through all
//   four input vectors in the order (a,b)=00,10,01,11, waits a settle time per
//   vector, samples the gate output and compares the result against a truth table.
//   Sits between a lab-board start button/host and the gate under test. Gives a
//   single pass flag plus per-vector results for display.
// PARAMETERS
//   SETTLE_CYCLES  2        cycles each vector is held before sampling (legal >= 1)
//   EXPECTED       4'b0111  expected gate_y per vector; bit i = vector idx i (NAND)
// PORTS
//   clk         in   1  single clock, all state on rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   start       in   1  request a sweep; accepted only in IDLE
//   abort       in   1  cancel a running sweep
//   gate_a      out  1  gate input 1 = idx[0]
//   gate_b      out  1  gate input 2 = idx[1]
//   gate_y      in   1  gate output, sampled in SAMPLE
//   busy        out  1  high in SETTLE and SAMPLE
//   done        out  1  one-cycle pulse when a sweep completes (not on abort)
//   pass        out  1  result_vec == EXPECTED; valid from done until next start
//   result_vec  out  4  sampled gate_y per vector idx
//   fail_mask   out  4  result_vec ^ EXPECTED, registered with pass
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, idx=0, cnt=0; all outputs 0.
//   States: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE:   start=1 & abort=0 -> SETTLE; idx=0, cnt=0, result_vec/fail_mask/pass
//             cleared. gate_a/gate_b hold 0.
//   - SETTLE: gate_a/b driven from idx (registered); cnt++ each cycle;
//             cnt==SETTLE_CYCLES-1 -> SAMPLE.
//   - SAMPLE: result_vec[idx] <= gate_y; idx==3 -> DONE, else idx++, cnt=0 -> SETTLE.
//   - DONE:   done=1 for this cycle; pass and fail_mask registered; -> IDLE.
//   Per vector = SETTLE_CYCLES+1 cycles; done asserts 4*(SETTLE_CYCLES+1)+1 cycles
//   after the start-accept edge (13 for default).
//   Boundaries:
//   - start while busy or in DONE: ignored, no restart.
//   - abort in SETTLE/SAMPLE: next state IDLE, idx=0, gate_a/b=0, done stays 0,
//     pass=0, partially filled result_vec retained.
//   - start & abort same cycle in IDLE: abort wins, stay IDLE.
//   - SETTLE_CYCLES=1: SETTLE lasts exactly one cycle per vector.
//   - rst_n low mid-sweep: immediate return to reset values, no done pulse.
//   - gate_y X/unknown is not filtered; it is captured as sampled.
//   cnt width = $clog2(SETTLE_CYCLES+1); idx is 2 bits, never wraps past 3.
// STRUCTURE
//   Package dld_gate_pkg: sweep_state_t enum (IDLE,SETTLE,SAMPLE,DONE); truth-table
//   constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
//   Sub-module settle_timer (load/en/expired, width from SETTLE_CYCLES) holds cnt;
//   FSM, idx, capture and compare stay in gate_sweep_ctrl.
// TESTING
//   1 Gate model = ideal NAND, pulse start -> a/b sequence 00,10,01,11 each held 2
//     cycles+sample, done at cycle 13, result_vec=4'b0111, pass=1, fail_mask=0.
//   2 Gate model stuck-at-1 -> result_vec=4'b1111, pass=0, fail_mask=4'b1000.
//   3 abort during vector idx=2 -> IDLE next cycle, gate_a/b=0, no done, busy=0;
//     following start completes normally with pass=1.
//   4 start held high whole sweep -> exactly one sweep, one done; second sweep
//     begins only after start seen in IDLE.
//   5 rst_n asserted mid-SETTLE (async, off-edge) -> all outputs 0 immediately;
//     start and abort same cycle in IDLE -> stays IDLE.
//   6 SETTLE_CYCLES=1, EXPECTED=TT_XOR with XOR model -> done at cycle 9, pass=1.

Source files
------------

// File: rtl/dld_gate_pkg.sv
// Shared types and truth-table constants for the gate sweep sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dld_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Bit i is the gate output for input vector idx i, where a = idx[0], b = idx[1].
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Per-vector settle counter: counts cycles a gate input vector has been held.
// Latency: expired is combinational from the registered count.
// Backpressure: none; load has priority over en.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   load        clear the count to zero
//   en          advance the count by one
//   expired     count has reached SETTLE_CYCLES-1 (last settle cycle)
module settle_timer #(
    parameter int SETTLE_CYCLES = 2,
    localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives a 2-input gate through vectors 00,10,01,11, samples its output, compares to a truth table.
// Latency: done pulses 4*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
// Backpressure: start is ignored unless idle; abort cancels a running sweep without done.
//
// Ports:
//   clk, rst_n       clock and async active-low reset
//   start, abort     sweep request / cancel
//   gate_a, gate_b   registered drive to the gate under test (idx[0], idx[1])
//   gate_y           gate output, captured once per vector
//   busy             sweep in progress
//   done             one-cycle completion pulse
//   pass, fail_mask  comparison of result_vec with EXPECTED, valid from done
//   result_vec       captured gate output per vector idx
module gate_sweep_ctrl
    import dld_gate_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = TT_NAND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result_vec,
    output logic [3:0] fail_mask
);

    sweep_state_t state;
    logic [1:0]   idx;
    logic         tmr_load;
    logic         tmr_en;
    logic         tmr_expired;

    // The count restarts whenever a vector begins: on accept (from IDLE),
    // after each sample, and on abort.
    assign tmr_load = (state == IDLE) || (state == SAMPLE) || abort;
    assign tmr_en   = (state == SETTLE);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            result_vec <= 4'd0;
            fail_mask  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        state      <= SETTLE;
                        idx        <= 2'd0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        result_vec <= 4'd0;
                        fail_mask  <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state  <= IDLE;
                        idx    <= 2'd0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                    end else if (tmr_expired) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        // an aborted sample is not captured; earlier vectors stay
                        state  <= IDLE;
                        idx    <= 2'd0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                        busy   <= 1'b0;
                        pass   <= 1'b0;
                    end else begin
                        // captured as-is, unknowns included
                        result_vec[idx] <= gate_y;
                        if (idx == 2'd3) begin
                            state  <= DONE;
                            gate_a <= 1'b0;
                            gate_b <= 1'b0;
                            busy   <= 1'b0;
                        end else begin
                            state           <= SETTLE;
                            idx             <= idx + 2'd1;
                            {gate_b, gate_a} <= idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    idx       <= 2'd0;
                    done      <= 1'b1;
                    pass      <= (result_vec == EXPECTED);
                    fail_mask <= result_vec ^ EXPECTED;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (default timing/NAND and one-cycle settle/XOR),
// directed scenarios plus randomized gate truth tables and abort points, checked
// against an arithmetic model of the sweep timeline.
module tb_gate_sweep_ctrl;
    import dld_gate_pkg::*;

    localparam int         S0 = 2;
    localparam int         S1 = 1;
    localparam logic [3:0] E0 = TT_NAND;
    localparam logic [3:0] E1 = TT_XOR;

    logic       clk;
    logic       rst_n;
    logic       start_i [2];
    logic       abort_i [2];
    logic       ga      [2];
    logic       gb      [2];
    logic       gy      [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [3:0] rv_o    [2];
    logic [3:0] fm_o    [2];
    logic [3:0] tt_m    [2];

    int tests_run;
    int tests_failed;

    // Gate models: output looked up from the model truth table by vector {b,a}.
    assign gy[0] = tt_m[0][{gb[0], ga[0]}];
    assign gy[1] = tt_m[1][{gb[1], ga[1]}];

    gate_sweep_ctrl #(.SETTLE_CYCLES(S0), .EXPECTED(E0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .abort(abort_i[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .gate_y(gy[0]), .busy(busy_o[0]),
        .done(done_o[0]), .pass(pass_o[0]), .result_vec(rv_o[0]), .fail_mask(fm_o[0])
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(S1), .EXPECTED(E1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .abort(abort_i[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .gate_y(gy[1]), .busy(busy_o[1]),
        .done(done_o[1]), .pass(pass_o[1]), .result_vec(rv_o[1]), .fail_mask(fm_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int k, input string tag);
        chk({tag, "_busy"}, 4'(busy_o[k]), 4'd0);
        chk({tag, "_gate_a"}, 4'(ga[k]), 4'd0);
        chk({tag, "_gate_b"}, 4'(gb[k]), 4'd0);
        chk({tag, "_done"}, 4'(done_o[k]), 4'd0);
        chk({tag, "_pass"}, 4'(pass_o[k]), 4'd0);
        chk({tag, "_result_vec"}, rv_o[k], 4'd0);
        chk({tag, "_fail_mask"}, fm_o[k], 4'd0);
    endtask

    // One sweep on instance k with gate truth table tt. abort_at >= 0 aborts
    // the sweep on the edge after timeline step abort_at. hold keeps start high.
    task automatic sweep(input int k, input logic [3:0] tt, input int abort_at, input bit hold);
        int         s;
        int         per;
        int         n;
        int         v;
        logic [3:0] exp_tt;
        logic [3:0] partial;
        s      = (k == 0) ? S0 : S1;
        exp_tt = (k == 0) ? E0 : E1;
        per    = s + 1;
        n      = 4 * per;
        tt_m[k] = tt;
        chk("idle_before_start", 4'(busy_o[k]), 4'd0);
        start_i[k] = 1'b1;
        tick;
        if (!hold) start_i[k] = 1'b0;
        for (int e = 0; e < n; e++) begin
            v = e / per;
            chk("busy_in_sweep", 4'(busy_o[k]), 4'd1);
            chk("gate_a_vec", 4'(ga[k]), 4'(v & 1));
            chk("gate_b_vec", 4'(gb[k]), 4'((v >> 1) & 1));
            chk("no_early_done", 4'(done_o[k]), 4'd0);
            if (e == 0) begin
                chk("pass_cleared", 4'(pass_o[k]), 4'd0);
                chk("result_cleared", rv_o[k], 4'd0);
            end
            if (e == abort_at) begin
                abort_i[k] = 1'b1;
                start_i[k] = 1'b0;
                tick;
                abort_i[k] = 1'b0;
                partial = 4'd0;
                for (int vv = 0; vv < v; vv++) partial[vv] = tt[vv];
                chk("abort_busy", 4'(busy_o[k]), 4'd0);
                chk("abort_gate_a", 4'(ga[k]), 4'd0);
                chk("abort_gate_b", 4'(gb[k]), 4'd0);
                chk("abort_pass", 4'(pass_o[k]), 4'd0);
                chk("abort_partial", rv_o[k], partial);
                for (int w = 0; w < n + 2; w++) begin
                    chk("abort_no_done", 4'(done_o[k]), 4'd0);
                    tick;
                end
                return;
            end
            tick;
        end
        chk("done_state_busy", 4'(busy_o[k]), 4'd0);
        chk("done_state_no_pulse_yet", 4'(done_o[k]), 4'd0);
        tick;
        chk("done_pulse", 4'(done_o[k]), 4'd1);
        chk("result_vec", rv_o[k], tt);
        chk("pass", 4'(pass_o[k]), 4'(tt == exp_tt));
        chk("fail_mask", fm_o[k], tt ^ exp_tt);
        tick;
        if (hold) begin
            // start still high: a new sweep is accepted only now, from idle
            chk("restart_busy", 4'(busy_o[k]), 4'd1);
            chk("restart_gate_a", 4'(ga[k]), 4'd0);
            chk("restart_no_done", 4'(done_o[k]), 4'd0);
            start_i[k] = 1'b0;
            abort_i[k] = 1'b1;
            tick;
            abort_i[k] = 1'b0;
            chk("restart_aborted", 4'(busy_o[k]), 4'd0);
            tick;
        end else begin
            chk("done_one_cycle", 4'(done_o[k]), 4'd0);
            chk("pass_held", 4'(pass_o[k]), 4'(tt == exp_tt));
            chk("idle_after_done", 4'(busy_o[k]), 4'd0);
        end
    endtask

    initial begin
        int         k;
        int         s;
        int         ab;
        logic [3:0] tt;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start_i[0]   = 1'b0;
        start_i[1]   = 1'b0;
        abort_i[0]   = 1'b0;
        abort_i[1]   = 1'b0;
        tt_m[0]      = TT_NAND;
        tt_m[1]      = TT_XOR;
        repeat (2) @(negedge clk);
        chk_all_zero(0, "reset0");
        chk_all_zero(1, "reset1");
        rst_n = 1'b1;
        tick;

        // ideal NAND
        sweep(0, TT_NAND, -1, 1'b0);
        // stuck-at-1 output
        sweep(0, 4'b1111, -1, 1'b0);
        // abort in the first settle cycle of vector 2, then a clean sweep
        sweep(0, TT_NAND, 2 * (S0 + 1), 1'b0);
        sweep(0, TT_NAND, -1, 1'b0);
        // start held high throughout
        sweep(0, TT_NAND, -1, 1'b1);

        // async reset mid-settle, away from the clock edge
        tt_m[0] = TT_NAND;
        start_i[0] = 1'b1;
        tick;
        start_i[0] = 1'b0;
        tick;
        chk("pre_reset_busy", 4'(busy_o[0]), 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero(0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_reset_idle", 4'(busy_o[0]), 4'd0);

        // start and abort together in idle
        start_i[0] = 1'b1;
        abort_i[0] = 1'b1;
        tick;
        chk("start_abort_idle", 4'(busy_o[0]), 4'd0);
        chk("start_abort_gate", 4'(ga[0]), 4'd0);
        start_i[0] = 1'b0;
        abort_i[0] = 1'b0;
        tick;
        chk("start_abort_no_done", 4'(done_o[0]), 4'd0);

        // one-cycle settle with XOR
        sweep(1, TT_XOR, -1, 1'b0);

        // randomized gate behaviour and abort points on both instances
        for (int i = 0; i < 10; i++) begin
            k  = i % 2;
            s  = (k == 0) ? S0 : S1;
            tt = 4'($urandom_range(0, 15));
            ab = -1;
            if ($urandom_range(0, 2) == 0)
                ab = int'($urandom_range(0, 3)) * (s + 1) + int'($urandom_range(0, s - 1));
            sweep(k, tt, ab, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
